// File: rtl/single_port_ram.sv
// single_port_ram: synchronous single-port RAM with one shared address bus.
// Writes and reads share the rising clock edge. Reads are registered and take
// one cycle. A read in the same cycle as a write returns the new data.
// Addresses at or above DEPTH ignore writes and read back as zero.
// Optional feature macro: RAM_PARITY_EN. When it is defined, each word stores
// an even-parity bit and reads report a mismatch on parity_err. When it is
// not defined, parity_err is tied to 0.
module single_port_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  parity_err
);

`ifdef RAM_PARITY_EN
    localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] wr_word;
    logic                  in_range;

    // A full address space needs no range check, so the compare only exists
    // when some address codes fall outside the array.
    generate
        if (DEPTH < (1 << ADDR_WIDTH)) begin : g_partial
            assign in_range = (32'(addr) < 32'(DEPTH));
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

`ifdef RAM_PARITY_EN
    assign wr_word = {^data, data};
`else
    assign wr_word = data;
`endif

    // Store the word on a write edge. A write on a reset edge is dropped, and
    // reset never clears the array contents.
    always_ff @(posedge clk) begin
        if (rst_n && we && in_range) begin
            mem[addr] <= wr_word;
        end
    end

    // Registered read data. A read during a write returns the incoming data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!in_range) begin
            q <= '0;
        end else if (we) begin
            q <= data;
        end else begin
            q <= mem[addr][DATA_WIDTH-1:0];
        end
    end

`ifdef RAM_PARITY_EN
    // Parity check on the stored word, registered alongside q. Parity is
    // always clean on a write-first read because it comes from the incoming
    // data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (!in_range || we) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= mem[addr][DATA_WIDTH] ^ (^mem[addr][DATA_WIDTH-1:0]);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_single_port_ram.sv
// Testbench for single_port_ram. It applies directed vectors from a table,
// then a few hand-written sequences, then random traffic. Random traffic is
// checked against an array model of the memory.
module tb_single_port_ram;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] q;
    logic          parity_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    single_port_ram #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .addr      (addr),
        .we        (we),
        .q         (q),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst_n;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    logic [DW-1:0] ref_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst_n = r;
        we    = w;
        addr  = a;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(vecs[i].rst_n, vecs[i].we, vecs[i].addr, vecs[i].data);
            check({vecs[i].name, "_q"}, 32'(q), 32'(vecs[i].exp_q));
            check({vecs[i].name, "_perr"}, 32'(parity_err), 32'(0));
        end
    endtask

    initial begin
        logic          r, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;

        // Reset is held with a write presented, and the write must be dropped.
        vecs.push_back('{"rst0",  1'b0, 1'b1, 6'd0,  8'hFF, 8'h00});
        vecs.push_back('{"rst1",  1'b0, 1'b1, 6'd0,  8'hFF, 8'h00});
        // Write-first returns the data just written.
        vecs.push_back('{"wf0",   1'b1, 1'b1, 6'd0,  8'h01, 8'h01});
        vecs.push_back('{"wf1",   1'b1, 1'b1, 6'd1,  8'h02, 8'h02});
        vecs.push_back('{"wf2",   1'b1, 1'b1, 6'd2,  8'h03, 8'h03});
        // Readback.
        vecs.push_back('{"rd0",   1'b1, 1'b0, 6'd0,  8'h00, 8'h01});
        vecs.push_back('{"rd1",   1'b1, 1'b0, 6'd1,  8'h00, 8'h02});
        vecs.push_back('{"rd2",   1'b1, 1'b0, 6'd2,  8'h00, 8'h03});
        // Overwrite at the top address.
        vecs.push_back('{"ow0",   1'b1, 1'b1, 6'd63, 8'hA5, 8'hA5});
        vecs.push_back('{"ow1",   1'b1, 1'b1, 6'd63, 8'h5A, 8'h5A});
        vecs.push_back('{"rd63",  1'b1, 1'b0, 6'd63, 8'h00, 8'h5A});
        vecs.push_back('{"rd0b",  1'b1, 1'b0, 6'd0,  8'h00, 8'h01});
        // Reset in the middle of a write.
        vecs.push_back('{"rstwr", 1'b0, 1'b1, 6'd1,  8'hEE, 8'h00});
        vecs.push_back('{"rd1b",  1'b1, 1'b0, 6'd1,  8'h00, 8'h02});

        rst_n = 1'b0;
        we    = 1'b1;
        addr  = '0;
        data  = 8'hFF;

        apply_range(0, 1);
        // Address 0 was never written before reset, so it must not read back
        // the data that was presented during reset.
        step(1'b1, 1'b0, 6'd0, 8'h00);
        n_cmp++;
        if (q === 8'hFF) begin
            n_bad++;
            $display("FAIL rst_nowrite: got %0h expected not ff", q);
        end
        apply_range(2, vecs.size() - 1);

        // Write then read the same address back to back.
        step(1'b1, 1'b1, 6'd10, 8'h77);
        check("b2b_wr", 32'(q), 32'h77);
        step(1'b1, 1'b0, 6'd10, 8'h00);
        check("b2b_rd", 32'(q), 32'h77);
        step(1'b1, 1'b0, 6'd63, 8'h00);
        check("b2b_rd63", 32'(q), 32'h5A);

        // Hold reset for several cycles while writes are presented. Then
        // confirm the contents survived and no write landed.
        step(1'b0, 1'b1, 6'd10, 8'h11);
        check("rsthold0", 32'(q), 32'h00);
        step(1'b0, 1'b1, 6'd2, 8'h22);
        check("rsthold1", 32'(q), 32'h00);
        step(1'b1, 1'b0, 6'd10, 8'h00);
        check("rsthold_rd10", 32'(q), 32'h77);
        step(1'b1, 1'b0, 6'd2, 8'h00);
        check("rsthold_rd2", 32'(q), 32'h03);

`ifdef RAM_PARITY_EN
        step(1'b1, 1'b0, 6'd63, 8'h00);
        check("par_clean_q", 32'(q), 32'h5A);
        check("par_clean", 32'(parity_err), 32'(0));
        dut.mem[63][DW] = ~dut.mem[63][DW];
        step(1'b1, 1'b0, 6'd63, 8'h00);
        check("par_flip_q", 32'(q), 32'h5A);
        check("par_flip", 32'(parity_err), 32'(1));
        step(1'b1, 1'b1, 6'd63, 8'h5A);
        check("par_wf", 32'(parity_err), 32'(0));
        step(1'b1, 1'b0, 6'd63, 8'h00);
        check("par_fixed", 32'(parity_err), 32'(0));
`endif

        // Fill every address so that the model knows the whole array.
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'($urandom);
            ref_mem[i] = d;
            step(1'b1, 1'b1, AW'(i), d);
            check("fill", 32'(q), 32'(d));
        end

        // Random mix of reads, writes and occasional resets.
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 19) != 0);
            w = $urandom_range(0, 1) != 0;
            a = AW'($urandom_range(0, DEPTH - 1));
            d = DW'($urandom);
            if (!r) begin
                exp = '0;
            end else if (w) begin
                ref_mem[a] = d;
                exp = d;
            end else begin
                exp = ref_mem[a];
            end
            step(r, w, a, d);
            check("rand_q", 32'(q), 32'(exp));
            check("rand_perr", 32'(parity_err), 32'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
